// File: rtl/ide_pio_sequencer.sv
// IDE PIO cycle sequencer for a 68000 bus: chip selects, IOR/IOW strobes with
// per-mode setup/active/recovery timing, IORDY wait extension and DTACK hand-off.
module ide_pio_sequencer #(
  parameter int unsigned DEFAULT_MODE = 0,
  parameter int unsigned IORDY_MAX    = 64
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       AS_n,
  input  logic       ide_access,
  input  logic       RW,
  input  logic [1:0] ADDR,
  input  logic       IORDY,
  input  logic       cfg_wr,
  input  logic [1:0] cfg_mode,
  output logic       IDECS1_n,
  output logic       IDECS2_n,
  output logic       IOR_n,
  output logic       IOW_n,
  output logic       DTACK,
  output logic       busy,
  output logic       iordy_timeout
);

  localparam int unsigned WW = $clog2(IORDY_MAX + 1);
  localparam logic [WW-1:0] WMAX = WW'(IORDY_MAX);
  localparam logic [1:0] DEF_MODE = 2'(DEFAULT_MODE);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACTIVE, S_WAIT, S_DONE, S_RECOVER
  } state_t;

  state_t        r_state;
  logic [1:0]    r_mode;
  logic [1:0]    r_tmode;
  logic          r_rw;
  logic [2:0]    r_cnt;
  logic [WW-1:0] r_wcnt;
  logic          r_as_s1, r_as_s2;
  logic          r_iordy_s1, r_iordy_s2;
  logic          r_cs1_n, r_cs2_n, r_ior_n, r_iow_n;
  logic          r_dtack, r_busy, r_tmo;
  logic          w_abort;

  // Timing tables hold (cycles - 1) so a counter reaching zero marks the last cycle.
  function automatic logic [2:0] setup_m1(input logic [1:0] m);
    case (m)
      2'd0:    return 3'd2;
      2'd1:    return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] active_m1(input logic [1:0] m);
    case (m)
      2'd0:    return 3'd7;
      2'd1:    return 3'd5;
      2'd2:    return 3'd3;
      default: return 3'd2;
    endcase
  endfunction

  function automatic logic [2:0] recover_m1(input logic [1:0] m);
    case (m)
      2'd0:    return 3'd5;
      2'd1:    return 3'd3;
      2'd2:    return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  assign w_abort = r_as_s2 &&
                   (r_state == S_SETUP || r_state == S_ACTIVE || r_state == S_WAIT);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_mode     <= DEF_MODE;
      r_tmode    <= DEF_MODE;
      r_rw       <= 1'b0;
      r_cnt      <= '0;
      r_wcnt     <= '0;
      r_as_s1    <= 1'b1;
      r_as_s2    <= 1'b1;
      r_iordy_s1 <= 1'b1;
      r_iordy_s2 <= 1'b1;
      r_cs1_n    <= 1'b1;
      r_cs2_n    <= 1'b1;
      r_ior_n    <= 1'b1;
      r_iow_n    <= 1'b1;
      r_dtack    <= 1'b0;
      r_busy     <= 1'b0;
      r_tmo      <= 1'b0;
    end else begin
      r_as_s1    <= AS_n;
      r_as_s2    <= r_as_s1;
      r_iordy_s1 <= IORDY;
      r_iordy_s2 <= r_iordy_s1;

      if (cfg_wr) begin
        r_mode <= cfg_mode;
        r_tmo  <= 1'b0;
      end

      if (w_abort) begin
        r_state <= S_RECOVER;
        r_cs1_n <= 1'b1;
        r_cs2_n <= 1'b1;
        r_ior_n <= 1'b1;
        r_iow_n <= 1'b1;
        r_cnt   <= recover_m1(r_tmode);
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!r_as_s2 && ide_access) begin
              r_state <= S_SETUP;
              r_rw    <= RW;
              r_tmode <= r_mode;
              r_cnt   <= setup_m1(r_mode);
              r_cs1_n <= ~ADDR[0];
              r_cs2_n <= ~ADDR[1];
              r_busy  <= 1'b1;
            end
          end
          S_SETUP: begin
            if (r_cnt == '0) begin
              r_state <= S_ACTIVE;
              r_cnt   <= active_m1(r_tmode);
              r_ior_n <= ~r_rw;
              r_iow_n <= r_rw;
            end else begin
              r_cnt <= r_cnt - 3'd1;
            end
          end
          S_ACTIVE: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - 3'd1;
            end else if (!r_iordy_s2) begin
              r_state <= S_WAIT;
              r_wcnt  <= WW'(1);
            end else begin
              r_state <= S_DONE;
              r_ior_n <= 1'b1;
              r_iow_n <= 1'b1;
              r_dtack <= 1'b1;
            end
          end
          S_WAIT: begin
            if (r_iordy_s2 || r_wcnt == WMAX) begin
              r_state <= S_DONE;
              r_ior_n <= 1'b1;
              r_iow_n <= 1'b1;
              r_dtack <= 1'b1;
              if (!r_iordy_s2) r_tmo <= 1'b1;
            end else begin
              r_wcnt <= r_wcnt + WW'(1);
            end
          end
          S_DONE: begin
            if (r_as_s2) begin
              r_state <= S_RECOVER;
              r_cs1_n <= 1'b1;
              r_cs2_n <= 1'b1;
              r_dtack <= 1'b0;
              r_cnt   <= recover_m1(r_tmode);
            end
          end
          S_RECOVER: begin
            if (r_cnt == '0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 3'd1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign IDECS1_n      = r_cs1_n;
  assign IDECS2_n      = r_cs2_n;
  assign IOR_n         = r_ior_n;
  assign IOW_n         = r_iow_n;
  assign DTACK         = r_dtack;
  assign busy          = r_busy;
  assign iordy_timeout = r_tmo;

endmodule

// File: tb/tb_ide_pio_sequencer.sv
// Directed bench for ide_pio_sequencer: a vector table of whole transactions with
// hand-computed phase lengths, plus a reset-during-WAIT sequence.
module tb_ide_pio_sequencer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       AS_n = 1'b1;
  logic       ide_access = 1'b0;
  logic       RW = 1'b1;
  logic [1:0] ADDR = 2'b00;
  logic       IORDY = 1'b1;
  logic       cfg_wr = 1'b0;
  logic [1:0] cfg_mode = 2'd0;
  logic       IDECS1_n, IDECS2_n, IOR_n, IOW_n, DTACK, busy, iordy_timeout;

  int n_checks = 0;
  int n_fail = 0;

  ide_pio_sequencer #(.DEFAULT_MODE(0), .IORDY_MAX(64)) dut (
    .CLK(CLK), .RESET(RESET), .AS_n(AS_n), .ide_access(ide_access), .RW(RW),
    .ADDR(ADDR), .IORDY(IORDY), .cfg_wr(cfg_wr), .cfg_mode(cfg_mode),
    .IDECS1_n(IDECS1_n), .IDECS2_n(IDECS2_n), .IOR_n(IOR_n), .IOW_n(IOW_n),
    .DTACK(DTACK), .busy(busy), .iordy_timeout(iordy_timeout)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       set_m;
    logic [1:0] mode;
    logic       rw;
    logic [1:0] addr;
    int         iordy_rel;  // 0: IORDY high, >0: release at that strobe cycle, -1: stuck low
    int         abort_at;   // strobe cycle at which AS_n is raised, 0 = no abort
    int         cfg_at;     // negedges after request start for a cfg_wr pulse, 0 = none
    logic [1:0] cfg_new;
    int         e_setup, e_act, e_dtack, e_rec;
    logic       e_cs1, e_cs2, e_tmo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_mode(input logic [1:0] m);
    cfg_wr = 1'b1;
    cfg_mode = m;
    @(negedge CLK);
    cfg_wr = 1'b0;
  endtask

  task automatic cfg_pulse(input int at, input logic [1:0] m);
    repeat (at) @(negedge CLK);
    cfg_wr = 1'b1;
    cfg_mode = m;
    @(negedge CLK);
    cfg_wr = 1'b0;
  endtask

  // Runs one bus cycle starting at a negedge and measures each phase in cycles.
  task automatic run_txn(input logic rw, input logic [1:0] addr, input int iordy_rel,
                         input int abort_at,
                         output int n_setup, output int n_act, output int n_dtack,
                         output int n_rec, output logic cs1, output logic cs2,
                         output logic ior_seen, output logic iow_seen,
                         output logic both_low, output logic rec_cs_hi);
    int k;
    n_setup = 0; n_act = 0; n_dtack = 0; n_rec = 0;
    ior_seen = 1'b0; iow_seen = 1'b0; both_low = 1'b0;
    if (iordy_rel != 0) IORDY = 1'b0;
    RW = rw; ADDR = addr; ide_access = 1'b1; AS_n = 1'b0;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (IDECS1_n && IDECS2_n && k < 20);
    cs1 = IDECS1_n;
    cs2 = IDECS2_n;
    while (IOR_n && IOW_n && n_setup < 40) begin
      if (DTACK) n_dtack++;
      n_setup++;
      @(negedge CLK);
    end
    while (!(IOR_n && IOW_n) && n_act < 200) begin
      if (!IOR_n) ior_seen = 1'b1;
      if (!IOW_n) iow_seen = 1'b1;
      if (!IOR_n && !IOW_n) both_low = 1'b1;
      if (DTACK) n_dtack++;
      n_act++;
      if (n_act == iordy_rel) IORDY = 1'b1;
      if (n_act == abort_at) AS_n = 1'b1;
      @(negedge CLK);
    end
    IORDY = 1'b1;
    if (abort_at == 0) begin
      for (int i = 0; i < 3; i++) begin
        if (DTACK) n_dtack++;
        @(negedge CLK);
      end
      AS_n = 1'b1;
      k = 0;
      while (DTACK && k < 20) begin
        n_dtack++;
        k++;
        @(negedge CLK);
      end
    end
    ide_access = 1'b0;
    rec_cs_hi = IDECS1_n & IDECS2_n;
    while (busy && n_rec < 50) begin
      if (DTACK) n_dtack++;
      n_rec++;
      @(negedge CLK);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ns, na, nd, nr, k;
    logic c1, c2, ir, iw, bl, rch;
    string tag;

    // DTACK-high count is 3 DONE cycles held plus 3 cycles of AS_n sync latency.
    vecs[0] = '{1'b1, 2'd0, 1'b1, 2'b01,  0, 0, 0, 2'd0, 3,  8, 6, 6, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 2'd3, 1'b0, 2'b10,  0, 0, 0, 2'd0, 1,  3, 6, 1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 2'd1, 1'b1, 2'b11,  0, 0, 0, 2'd0, 2,  6, 6, 4, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 2'd2, 1'b1, 2'b01, 14, 0, 0, 2'd0, 1, 16, 6, 2, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 2'd2, 1'b1, 2'b01, -1, 0, 0, 2'd0, 1, 68, 6, 2, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 2'd0, 1'b0, 2'b01,  0, 2, 0, 2'd0, 3,  4, 0, 6, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 2'd0, 1'b1, 2'b01,  0, 0, 2, 2'd3, 3,  8, 6, 6, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 2'd0, 1'b0, 2'b10,  0, 0, 0, 2'd0, 1,  3, 6, 1, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 2'd0, 1'b1, 2'b10,  0, 0, 8, 2'd3, 3,  8, 6, 6, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 2'd0, 1'b1, 2'b01,  0, 0, 0, 2'd0, 1,  3, 6, 1, 1'b0, 1'b1, 1'b0};

    repeat (3) @(negedge CLK);
    chk("reset IDECS1_n", int'(IDECS1_n), 1);
    chk("reset IDECS2_n", int'(IDECS2_n), 1);
    chk("reset IOR_n", int'(IOR_n), 1);
    chk("reset IOW_n", int'(IOW_n), 1);
    chk("reset DTACK", int'(DTACK), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset iordy_timeout", int'(iordy_timeout), 0);
    RESET = 1'b0;
    @(negedge CLK);

    for (int v = 0; v < 10; v++) begin
      tag = $sformatf("v%0d", v);
      if (vecs[v].set_m) begin
        set_mode(vecs[v].mode);
        chk({tag, " timeout cleared"}, int'(iordy_timeout), 0);
      end
      if (vecs[v].cfg_at != 0) begin
        fork
          run_txn(vecs[v].rw, vecs[v].addr, vecs[v].iordy_rel, vecs[v].abort_at,
                  ns, na, nd, nr, c1, c2, ir, iw, bl, rch);
          cfg_pulse(vecs[v].cfg_at, vecs[v].cfg_new);
        join
      end else begin
        run_txn(vecs[v].rw, vecs[v].addr, vecs[v].iordy_rel, vecs[v].abort_at,
                ns, na, nd, nr, c1, c2, ir, iw, bl, rch);
      end
      chk({tag, " setup cycles"}, ns, vecs[v].e_setup);
      chk({tag, " strobe cycles"}, na, vecs[v].e_act);
      chk({tag, " DTACK cycles"}, nd, vecs[v].e_dtack);
      chk({tag, " recovery cycles"}, nr, vecs[v].e_rec);
      chk({tag, " IDECS1_n"}, int'(c1), int'(vecs[v].e_cs1));
      chk({tag, " IDECS2_n"}, int'(c2), int'(vecs[v].e_cs2));
      chk({tag, " IOR_n used"}, int'(ir), int'(vecs[v].rw));
      chk({tag, " IOW_n used"}, int'(iw), int'(!vecs[v].rw));
      chk({tag, " both strobes low"}, int'(bl), 0);
      chk({tag, " CS high in recovery"}, int'(rch), 1);
      chk({tag, " iordy_timeout"}, int'(iordy_timeout), int'(vecs[v].e_tmo));
    end

    // Reset while stalled in WAIT, then confirm the default mode timing is back.
    set_mode(2'd2);
    IORDY = 1'b0; RW = 1'b1; ADDR = 2'b01; ide_access = 1'b1; AS_n = 1'b0;
    k = 0;
    while (IOR_n && k < 30) begin
      k++;
      @(negedge CLK);
    end
    repeat (10) @(negedge CLK);
    chk("wait IOR_n held", int'(IOR_n), 0);
    chk("wait busy", int'(busy), 1);
    RESET = 1'b1;
    @(negedge CLK);
    chk("midreset IDECS1_n", int'(IDECS1_n), 1);
    chk("midreset IDECS2_n", int'(IDECS2_n), 1);
    chk("midreset IOR_n", int'(IOR_n), 1);
    chk("midreset IOW_n", int'(IOW_n), 1);
    chk("midreset DTACK", int'(DTACK), 0);
    chk("midreset busy", int'(busy), 0);
    RESET = 1'b0; AS_n = 1'b1; ide_access = 1'b0; IORDY = 1'b1;
    @(negedge CLK);
    run_txn(1'b1, 2'b01, 0, 0, ns, na, nd, nr, c1, c2, ir, iw, bl, rch);
    chk("postreset setup cycles", ns, 3);
    chk("postreset strobe cycles", na, 8);
    chk("postreset recovery cycles", nr, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ide_pio_sequencer.md
IDE_PIO_SEQUENCER -- requirements
Module: ide_pio_sequencer

Interface
REQ-001 SHALL have parameter DEFAULT_MODE, default 0, giving the PIO timing mode (0-3) loaded at reset.
REQ-002 SHALL have parameter IORDY_MAX, default 64, giving the maximum IORDY wait extension in CLK cycles.
REQ-003 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port AS_n  input  1  68000 address strobe; asynchronous, synchronised internally by 2 flops.
REQ-006 SHALL have port ide_access  input  1  decoded IDE register access, qualified with AS_n.
REQ-007 SHALL have port RW  input  1  bus direction; 1 = read.
REQ-008 SHALL have port ADDR  input  2  ADDR[13:12]; bit 0 selects CS1 and bit 1 selects CS2.
REQ-009 SHALL have port IORDY  input  1  drive ready; low extends the strobe; synchronised internally by 2 flops.
REQ-010 SHALL have port cfg_wr  input  1  one-cycle pulse that loads cfg_mode.
REQ-011 SHALL have port cfg_mode  input  2  requested PIO mode.
REQ-012 SHALL have port IDECS1_n and IDECS2_n  output  1 each  drive chip selects, active low.
REQ-013 SHALL have port IOR_n and IOW_n  output  1 each  drive strobes, active low.
REQ-014 SHALL have port DTACK  output  1  cycle-complete indication to the bus logic, active high.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port iordy_timeout  output  1  sticky flag; cleared by RESET or cfg_wr.

Function
REQ-017 SHALL implement the states IDLE, SETUP, ACTIVE, WAIT, DONE and RECOVER.
REQ-018 SHALL use these timings in CLK cycles (setup/active/recovery): mode0 3/8/6, mode1 2/6/4, mode2 1/4/2, mode3 1/3/1.
REQ-019 SHALL, in IDLE with synchronised AS_n low and ide_access high, latch RW, ADDR and the current mode, then enter SETUP on the next edge.
REQ-020 SHALL keep a transaction's timing fixed at the mode latched at its start.
REQ-021 SHALL assert the selected CS outputs from SETUP entry through DONE; they are deasserted in IDLE and RECOVER.
REQ-022 SHALL remain in SETUP for t_setup cycles and then enter ACTIVE.
REQ-023 SHALL, in ACTIVE, assert IOR_n low for a read or IOW_n low for a write, for t_active cycles.
REQ-024 SHALL enter WAIT instead of DONE when synchronised IORDY is low on the last ACTIVE cycle, with the strobe held.
REQ-025 SHALL leave WAIT for DONE when IORDY goes high, or after IORDY_MAX cycles, whichever comes first.
REQ-026 SHALL set iordy_timeout when WAIT exits because IORDY_MAX was reached.
REQ-027 SHALL, in DONE, hold both strobes high and DTACK high, and stay until synchronised AS_n is high, then enter RECOVER.
REQ-028 SHALL, in RECOVER, count t_recovery cycles with DTACK low, then enter IDLE; no new request is accepted before IDLE.
REQ-029 SHALL, if synchronised AS_n rises in SETUP, ACTIVE or WAIT (abort), enter RECOVER on the next edge: strobes and CS high, DTACK never asserted.
REQ-030 SHALL, on cfg_wr, update the mode register on the next edge; if busy, the new mode applies from the next transaction.
REQ-031 SHALL, when cfg_wr coincides with a request accepted in IDLE, use the old mode for that transaction.
REQ-032 SHALL drive all outputs registered, with no combinational path from inputs to outputs.
REQ-033 SHALL never have IOR_n and IOW_n low in the same cycle.

Reset
REQ-034 SHALL, while RESET is high, force state IDLE, mode = DEFAULT_MODE, counters 0, IOR_n = IOW_n = IDECS1_n = IDECS2_n = 1, DTACK = 0, busy = 0, iordy_timeout = 0 and the synchronisers to 1.
REQ-035 SHALL, on RESET asserted mid-transaction, deassert all strobes and selects and DTACK on the next edge.

Verification
REQ-036 Mode 0 read, ADDR=01, IORDY high -> IDECS1_n low 3 cycles before IOR_n, IOR_n low exactly 8 cycles, DTACK high until AS_n high, then 6 idle cycles.
REQ-037 cfg_wr mode 3 while idle, then a write with ADDR=10 -> IDECS2_n low, IOW_n low 3 cycles, recovery 1 cycle, IOR_n stays high.
REQ-038 Mode 2 read, IORDY low for 10 cycles from the last active cycle -> IOR_n low 4+10 (+sync) cycles, iordy_timeout stays 0; same stimulus with IORDY stuck low -> exit after 64 cycles, iordy_timeout = 1.
REQ-039 AS_n rises on the 2nd ACTIVE cycle -> strobe and CS high within the 2-flop sync latency + 1 cycle, DTACK never high, full recovery before the next request.
REQ-040 cfg_wr mode 3 issued during a mode 0 transaction -> the current transaction keeps mode 0 timing, the next one uses mode 3.
REQ-041 RESET pulsed during WAIT -> next edge all outputs at reset values, busy = 0, mode = DEFAULT_MODE.
